// File: rtl/fifo_wr_arb_ctrl.sv
// fifo_wr_arb_ctrl
//   Single-clock controller for the DSP FIFO memory. It arbitrates N_REQ write
//   requesters onto the memory's single write port in round-robin order. It
//   also owns the read/write pointers, derives full/empty/fill_count, and
//   provides a synchronous flush plus sticky overflow/underflow flags.
// Ports
//   w_clk, w_rst          clock (rising edge), asynchronous active-high reset
//   req_valid, req_data   per-requester valid and packed data words
//   req_ready             one-hot accept; zero-latency, combinational
//   rd_en, rd_ack         consumer pop request and accept (combinational)
//   flush, clr_err        synchronous pointer clear, sticky error clear
//   mem_w_inc/addr/data   write port of the external memory
//   mem_r_addr            head-entry read address of the external memory
//   full, empty           FIFO status flags
//   fill_count            number of entries stored, 0..F_DEPTH
//   ovf_err, unf_err      sticky error flags
module fifo_wr_arb_ctrl #(
  parameter int unsigned D_SIZE  = 8,
  parameter int unsigned F_DEPTH = 8,
  parameter int unsigned P_SIZE  = 4,
  parameter int unsigned N_REQ   = 2
) (
  input  logic                      w_clk,
  input  logic                      w_rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*D_SIZE-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      rd_en,
  output logic                      rd_ack,
  input  logic                      flush,
  input  logic                      clr_err,
  output logic                      mem_w_inc,
  output logic [P_SIZE-2:0]         mem_w_addr,
  output logic [D_SIZE-1:0]         mem_w_data,
  output logic [P_SIZE-2:0]         mem_r_addr,
  output logic                      full,
  output logic                      empty,
  output logic [P_SIZE-1:0]         fill_count,
  output logic                      ovf_err,
  output logic                      unf_err
);

  localparam int unsigned A_W  = P_SIZE - 1;
  localparam int unsigned RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(N_REQ - 1);

  // Depth must match the address space of the pointers
  if (F_DEPTH != (1 << A_W)) begin : g_depth_check
    $error("fifo_wr_arb_ctrl: F_DEPTH must equal 2**(P_SIZE-1)");
  end

  logic [P_SIZE-1:0] wr_ptr;
  logic [P_SIZE-1:0] rd_ptr;
  logic [RR_W-1:0]   rr_ptr;

  logic              grant_found;
  logic [RR_W-1:0]   grant_idx;
  logic              wr_acc;
  logic              ovf_set;
  logic              unf_set;

  logic [D_SIZE-1:0] req_word [N_REQ];

  // Unpack the flat requester data bus into words
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_word[i] = req_data[i*D_SIZE +: D_SIZE];
  end

  // Status derived from the pointers; the MSB is the wrap bit
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[A_W-1:0] == rd_ptr[A_W-1:0]) &&
                      (wr_ptr[P_SIZE-1] != rd_ptr[P_SIZE-1]);
  assign fill_count = wr_ptr - rd_ptr;
  assign mem_w_addr = wr_ptr[A_W-1:0];
  assign mem_r_addr = rd_ptr[A_W-1:0];

  // Round-robin search starting at rr_ptr, ascending with wrap
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (32'(rr_ptr) + 32'(k)) % N_REQ;
      if (!grant_found && req_valid[RR_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = RR_W'(idx);
      end
    end
  end

  // Reset gating keeps the combinational handshakes quiet while w_rst is high
  assign wr_acc     = grant_found && !full && !flush && !w_rst;
  assign req_ready  = wr_acc ? (N_REQ'(1) << grant_idx) : '0;
  assign mem_w_inc  = wr_acc;
  assign mem_w_data = req_word[grant_idx];
  assign rd_ack     = rd_en && !empty && !flush && !w_rst;

  assign ovf_set = (|req_valid) && full;
  assign unf_set = rd_en && empty;

  // Pointer and priority state; flush overrides any transfer
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rr_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + P_SIZE'(1);
        rr_ptr <= (grant_idx == RR_LAST) ? '0 : grant_idx + RR_W'(1);
      end
      if (rd_ack) begin
        rd_ptr <= rd_ptr + P_SIZE'(1);
      end
    end
  end

  // Sticky error flags; a new event wins over a clear in the same cycle
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_set | (ovf_err & ~clr_err);
      unf_err <= unf_set | (unf_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// tb_fifo_wr_arb_ctrl
//   Directed and randomized stimulus against a queue-based reference model of
//   the FIFO, with a behavioural memory attached to the controller's ports.
module tb_fifo_wr_arb_ctrl;

  localparam int D_SIZE  = 8;
  localparam int F_DEPTH = 8;
  localparam int P_SIZE  = 4;
  localparam int N_REQ   = 2;

  logic                    w_clk;
  logic                    w_rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*D_SIZE-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    rd_en;
  logic                    rd_ack;
  logic                    flush;
  logic                    clr_err;
  logic                    mem_w_inc;
  logic [P_SIZE-2:0]       mem_w_addr;
  logic [D_SIZE-1:0]       mem_w_data;
  logic [P_SIZE-2:0]       mem_r_addr;
  logic                    full;
  logic                    empty;
  logic [P_SIZE-1:0]       fill_count;
  logic                    ovf_err;
  logic                    unf_err;

  int checks;
  int failures;

  // Reference model state
  logic [D_SIZE-1:0] q[$];
  int wr_m, rd_m, rr_m;
  logic ovf_m, unf_m;

  logic [D_SIZE-1:0] mem [F_DEPTH];

  fifo_wr_arb_ctrl #(
    .D_SIZE(D_SIZE), .F_DEPTH(F_DEPTH), .P_SIZE(P_SIZE), .N_REQ(N_REQ)
  ) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rd_en(rd_en), .rd_ack(rd_ack), .flush(flush), .clr_err(clr_err),
    .mem_w_inc(mem_w_inc), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_addr(mem_r_addr), .full(full), .empty(empty),
    .fill_count(fill_count), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  // Behavioural memory driven by the controller's write port
  always @(posedge w_clk) begin
    if (mem_w_inc) mem[mem_w_addr] <= mem_w_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [D_SIZE-1:0] word(input int i);
    logic [N_REQ*D_SIZE-1:0] d;
    d = req_data;
    return d[i*D_SIZE +: D_SIZE];
  endfunction

  task automatic set_word(input int i, input logic [D_SIZE-1:0] v);
    req_data[i*D_SIZE +: D_SIZE] = v;
  endtask

  task automatic model_reset();
    q.delete();
    wr_m = 0; rd_m = 0; rr_m = 0;
    ovf_m = 1'b0; unf_m = 1'b0;
  endtask

  // One clock: check all outputs against the model, then advance both
  task automatic cycle();
    int g, n;
    logic found, exp_ack, set_o, set_u;
    logic [N_REQ-1:0] exp_rdy;
    #1;
    n = q.size();
    found = 1'b0; g = 0;
    for (int k = 0; k < N_REQ; k++) begin
      int idx;
      idx = (rr_m + k) % N_REQ;
      if (!found && req_valid[idx]) begin found = 1'b1; g = idx; end
    end
    exp_rdy = '0;
    if (found && n < F_DEPTH && !flush) exp_rdy[g] = 1'b1;
    exp_ack = rd_en && (n > 0) && !flush;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rd_ack", 32'(rd_ack), 32'(exp_ack));
    chk("mem_w_inc", 32'(mem_w_inc), 32'(|exp_rdy));
    if (|exp_rdy) begin
      chk("mem_w_data", 32'(mem_w_data), 32'(word(g)));
      chk("mem_w_addr", 32'(mem_w_addr), 32'(wr_m % F_DEPTH));
    end
    chk("mem_r_addr", 32'(mem_r_addr), 32'(rd_m % F_DEPTH));
    chk("full", 32'(full), 32'(n == F_DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("fill_count", 32'(fill_count), 32'(n));
    if (n > 0) chk("head", 32'(mem[mem_r_addr]), 32'(q[0]));
    chk("ovf_err", 32'(ovf_err), 32'(ovf_m));
    chk("unf_err", 32'(unf_err), 32'(unf_m));
    set_o = (|req_valid) && (n == F_DEPTH);
    set_u = rd_en && (n == 0);
    @(posedge w_clk);
    if (flush) begin
      q.delete();
      wr_m = 0; rd_m = 0; rr_m = 0;
    end else begin
      if (exp_ack) begin
        void'(q.pop_front());
        rd_m = (rd_m + 1) % (2 * F_DEPTH);
      end
      if (|exp_rdy) begin
        q.push_back(word(g));
        wr_m = (wr_m + 1) % (2 * F_DEPTH);
        rr_m = (g + 1) % N_REQ;
      end
    end
    ovf_m = set_o | (ovf_m & ~clr_err);
    unf_m = set_u | (unf_m & ~clr_err);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_fill"}, 32'(fill_count), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_winc"}, 32'(mem_w_inc), 32'd0);
    chk({tag, "_rdack"}, 32'(rd_ack), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_err), 32'd0);
    chk({tag, "_unf"}, 32'(unf_err), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    w_rst = 1'b1;
    req_valid = '0; req_data = '0;
    rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    model_reset();

    // Reset state, with live requests and a pop to show gating
    req_valid = 2'b11; rd_en = 1'b1;
    @(posedge w_clk); @(posedge w_clk); #1;
    check_reset_outputs("reset");
    req_valid = '0; rd_en = 1'b0;
    w_rst = 1'b0;

    // 1: eight writes from req0 fill the FIFO, ninth is refused
    for (int i = 0; i < 8; i++) begin
      req_valid = 2'b01; set_word(0, 8'(8'h11 + i));
      cycle();
    end
    chk("t1_full", 32'(full), 32'd1);
    chk("t1_fill", 32'(fill_count), 32'd8);
    set_word(0, 8'h19);
    cycle();
    chk("t1_ovf", 32'(ovf_err), 32'd1);
    req_valid = '0; flush = 1'b1; cycle();
    flush = 1'b0; clr_err = 1'b1; cycle();
    clr_err = 1'b0;
    chk("t1_ovf_clr", 32'(ovf_err), 32'd0);

    // 2: both requesters held valid -> grants alternate
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      set_word(0, 8'($urandom)); set_word(1, 8'($urandom));
      cycle();
    end

    // 3: fill with req0, then read and write together at full
    req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      set_word(0, 8'($urandom)); cycle();
    end
    set_word(0, 8'h77); rd_en = 1'b1;
    cycle();
    rd_en = 1'b0;
    cycle();
    chk("t3_fill", 32'(fill_count), 32'd8);
    chk("t3_head_addr", 32'(mem_r_addr), 32'd1);
    req_valid = '0; flush = 1'b1; cycle(); flush = 1'b0;

    // 4: fill 3, then 20 cycles of simultaneous read and write
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      set_word(1, 8'($urandom)); cycle();
    end
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req_valid = 2'($urandom_range(1, 3));
      set_word(0, 8'($urandom)); set_word(1, 8'($urandom));
      cycle();
    end
    rd_en = 1'b0; req_valid = '0;
    chk("t4_fill", 32'(fill_count), 32'd3);
    flush = 1'b1; cycle(); flush = 1'b0;

    // 5: underflow, clear, then a single write becomes head
    rd_en = 1'b1; cycle(); rd_en = 1'b0;
    chk("t5_unf", 32'(unf_err), 32'd1);
    clr_err = 1'b1; cycle(); clr_err = 1'b0;
    chk("t5_unf_clr", 32'(unf_err), 32'd0);
    req_valid = 2'b01; set_word(0, 8'hA5); cycle(); req_valid = '0;
    chk("t5_empty", 32'(empty), 32'd0);
    chk("t5_head", 32'(mem[mem_r_addr]), 32'hA5);

    // 6: fill 5, flush, priority back to requester 0
    req_valid = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_word(1, 8'($urandom)); cycle();
    end
    chk("t6_fill5", 32'(fill_count), 32'd5);
    req_valid = '0; flush = 1'b1; cycle(); flush = 1'b0;
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_fill0", 32'(fill_count), 32'd0);
    req_valid = 2'b11; #1;
    chk("t6_rr0", 32'(req_ready), 32'd1);
    cycle(); cycle();

    // Asynchronous reset in the middle of a burst
    req_valid = 2'b11; rd_en = 1'b1;
    #2 w_rst = 1'b1;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(posedge w_clk); #1;
    w_rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      req_valid = 2'($urandom);
      set_word(0, 8'($urandom)); set_word(1, 8'($urandom));
      rd_en   = 1'($urandom_range(0, 1));
      flush   = ($urandom_range(0, 31) == 0);
      clr_err = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
